// File: rtl/nv_nvdla_pdp_core_seq_pkg.sv
// Shared definitions for the PDP core sequencer slice.
//   seq_state_e : sequencer FSM state encoding
//   SPLIT_W     : width of split index / splitw_num
//   WID_W       : width of per-split output width fields (minus-one encoded)
//   CUBE_W      : width of cube height/channel fields (minus-one encoded)
package nv_nvdla_pdp_pkg;

    localparam int unsigned SPLIT_W = 8;
    localparam int unsigned WID_W   = 10;
    localparam int unsigned CUBE_W  = 13;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_START = 2'd1,
        SEQ_RUN   = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/nv_nvdla_pdp_core_seq_if.sv
// Datapath-to-WDMA output handshake, one element per accepted beat.
//   dp2wdma_valid : datapath has an element
//   dp2wdma_ready : WDMA accepts the element
// master: side driving the handshake; slave: monitoring side (sequencer).
interface nv_nvdla_pdp_core_seq_if;
    import nv_nvdla_pdp_pkg::*;

    logic dp2wdma_valid;
    logic dp2wdma_ready;

    modport master (output dp2wdma_valid, output dp2wdma_ready);
    modport slave  (input  dp2wdma_valid, input  dp2wdma_ready);

endinterface

// File: rtl/nv_nvdla_pdp_core_seq_cnt.sv
// Wrap counter used for the x / line / surface / split nest.
//   clr_i              : synchronous clear (highest priority)
//   load_i, load_val_i : synchronous load
//   inc_i              : advance by one, wrapping to 0 after limit_i
//   limit_i            : terminal value (minus-one encoded count)
//   cnt_o              : current count (registered)
//   carry_o            : combinational, inc_i while at limit_i
module nv_nvdla_pdp_seq_cnt
    import nv_nvdla_pdp_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         nvdla_core_clk,
    input  logic         nvdla_core_rstn,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] cnt_o,
    output logic         carry_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign carry_o = inc_i & (cnt_q == limit_i);
    assign cnt_o   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = carry_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nv_nvdla_pdp_core.sv
// PDP core operation sequencer.
// Inputs : nvdla_core_clk/nvdla_core_rstn, reg2dp_* configuration (op enable,
//          split count, per-split widths, cube height/channel, padding) and the
//          monitored dp2wdma handshake (interface slave modport).
// Outputs: pdp_op_start / split_done (decoded pulses), seq_busy, dp2reg_done,
//          seq_err and the current split's index, position, width and padding.
module nv_nvdla_pdp_core_seq
    import nv_nvdla_pdp_pkg::*;
#(
    parameter int unsigned SPLIT_W = nv_nvdla_pdp_pkg::SPLIT_W,
    parameter int unsigned WID_W   = nv_nvdla_pdp_pkg::WID_W,
    parameter int unsigned CUBE_W  = nv_nvdla_pdp_pkg::CUBE_W
) (
    input  logic                      nvdla_core_clk,
    input  logic                      nvdla_core_rstn,
    input  logic                      reg2dp_op_en,
    input  logic [SPLIT_W-1:0]        reg2dp_splitw_num,
    input  logic [WID_W-1:0]          reg2dp_partial_width_out_first,
    input  logic [WID_W-1:0]          reg2dp_partial_width_out_mid,
    input  logic [WID_W-1:0]          reg2dp_partial_width_out_last,
    input  logic [CUBE_W-1:0]         reg2dp_cube_out_height,
    input  logic [CUBE_W-1:0]         reg2dp_cube_out_channel,
    input  logic [2:0]                reg2dp_pad_left,
    input  logic [2:0]                reg2dp_pad_right,
    nv_nvdla_pdp_core_seq_if.slave    dp2wdma,
    output logic                      pdp_op_start,
    output logic                      seq_busy,
    output logic [SPLIT_W-1:0]        split_idx,
    output logic                      split_first,
    output logic                      split_last,
    output logic [WID_W-1:0]          cur_width_out,
    output logic [2:0]                cur_pad_left,
    output logic [2:0]                cur_pad_right,
    output logic                      split_done,
    output logic                      dp2reg_done,
    output logic                      seq_err
);

    seq_state_e state_q, state_d;
    logic       op_en_q;

    // Configuration latched at START
    logic [SPLIT_W-1:0] splitw_q;
    logic [WID_W-1:0]   w_first_q, w_mid_q, w_last_q;
    logic [CUBE_W-1:0]  height_q, chan_q;
    logic [2:0]         pad_l_q, pad_r_q;

    logic               busy_q, done_q, err_q, err_d;
    logic               first_q, last_q;
    logic [WID_W-1:0]   width_q, width_d;
    logic [2:0]         cur_pl_q, cur_pl_d, cur_pr_q, cur_pr_d;

    logic               beat, start, abort, run_beat, cnt_clr, upd;
    logic               x_carry, line_carry, surf_carry, split_carry;
    logic [WID_W-1:0]   x_cnt;
    logic [CUBE_W-1:0]  line_cnt, surf_cnt;
    logic [SPLIT_W-1:0] split_nxt, num_e;
    logic [WID_W-1:0]   first_e, mid_e, last_e;
    logic [2:0]         pl_e, pr_e;

    assign beat     = dp2wdma.dp2wdma_valid & dp2wdma.dp2wdma_ready;
    assign start    = reg2dp_op_en & ~op_en_q;
    assign abort    = ~reg2dp_op_en & ((state_q == SEQ_START) | (state_q == SEQ_RUN));
    assign run_beat = (state_q == SEQ_RUN) & beat & reg2dp_op_en;
    assign cnt_clr  = (state_q == SEQ_START) | abort;

    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_IDLE:  if (start) state_d = SEQ_START;
            SEQ_START: state_d = abort ? SEQ_IDLE : SEQ_RUN;
            SEQ_RUN: begin
                if (abort)            state_d = SEQ_IDLE;
                else if (split_carry) state_d = SEQ_DONE;
            end
            SEQ_DONE:  state_d = SEQ_IDLE;
            default:   state_d = SEQ_IDLE;
        endcase
    end

    nv_nvdla_pdp_seq_cnt #(.W(WID_W)) u_x_cnt (
        .nvdla_core_clk(nvdla_core_clk), .nvdla_core_rstn(nvdla_core_rstn),
        .clr_i(cnt_clr), .load_i(1'b0), .load_val_i('0), .inc_i(run_beat),
        .limit_i(width_q), .cnt_o(x_cnt), .carry_o(x_carry));

    nv_nvdla_pdp_seq_cnt #(.W(CUBE_W)) u_line_cnt (
        .nvdla_core_clk(nvdla_core_clk), .nvdla_core_rstn(nvdla_core_rstn),
        .clr_i(cnt_clr), .load_i(1'b0), .load_val_i('0), .inc_i(x_carry),
        .limit_i(height_q), .cnt_o(line_cnt), .carry_o(line_carry));

    nv_nvdla_pdp_seq_cnt #(.W(CUBE_W)) u_surf_cnt (
        .nvdla_core_clk(nvdla_core_clk), .nvdla_core_rstn(nvdla_core_rstn),
        .clr_i(cnt_clr), .load_i(1'b0), .load_val_i('0), .inc_i(line_carry),
        .limit_i(chan_q), .cnt_o(surf_cnt), .carry_o(surf_carry));

    nv_nvdla_pdp_seq_cnt #(.W(SPLIT_W)) u_split_cnt (
        .nvdla_core_clk(nvdla_core_clk), .nvdla_core_rstn(nvdla_core_rstn),
        .clr_i(cnt_clr), .load_i(1'b0), .load_val_i('0), .inc_i(surf_carry),
        .limit_i(splitw_q), .cnt_o(split_idx), .carry_o(split_carry));

    // Per-split outputs are recomputed from the split index the counter will
    // hold after this edge. In START the latch is still loading, so the raw
    // register values are used instead of the latched copies.
    always_comb begin
        num_e   = (state_q == SEQ_START) ? reg2dp_splitw_num              : splitw_q;
        first_e = (state_q == SEQ_START) ? reg2dp_partial_width_out_first : w_first_q;
        mid_e   = (state_q == SEQ_START) ? reg2dp_partial_width_out_mid   : w_mid_q;
        last_e  = (state_q == SEQ_START) ? reg2dp_partial_width_out_last  : w_last_q;
        pl_e    = (state_q == SEQ_START) ? reg2dp_pad_left                : pad_l_q;
        pr_e    = (state_q == SEQ_START) ? reg2dp_pad_right               : pad_r_q;

        split_nxt = split_idx;
        if (cnt_clr || split_carry) split_nxt = '0;
        else if (surf_carry)        split_nxt = split_idx + SPLIT_W'(1);

        if (num_e == '0 || split_nxt == '0) width_d = first_e;
        else if (split_nxt == num_e)        width_d = last_e;
        else                                width_d = mid_e;

        cur_pl_d = (split_nxt == '0)   ? pl_e : 3'd0;
        cur_pr_d = (split_nxt == num_e) ? pr_e : 3'd0;
        upd      = cnt_clr | surf_carry;

        err_d = err_q;
        if (state_q == SEQ_START)                err_d = 1'b0;
        else if (state_q == SEQ_IDLE && beat)    err_d = 1'b1;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q   <= SEQ_IDLE;
            op_en_q   <= 1'b0;
            splitw_q  <= '0;
            w_first_q <= '0;
            w_mid_q   <= '0;
            w_last_q  <= '0;
            height_q  <= '0;
            chan_q    <= '0;
            pad_l_q   <= '0;
            pad_r_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            first_q   <= 1'b1;
            last_q    <= 1'b0;
            width_q   <= '0;
            cur_pl_q  <= '0;
            cur_pr_q  <= '0;
        end else begin
            state_q <= state_d;
            op_en_q <= reg2dp_op_en;
            busy_q  <= (state_d != SEQ_IDLE);
            done_q  <= (state_d == SEQ_DONE);
            err_q   <= err_d;
            if (state_q == SEQ_START) begin
                splitw_q  <= reg2dp_splitw_num;
                w_first_q <= reg2dp_partial_width_out_first;
                w_mid_q   <= reg2dp_partial_width_out_mid;
                w_last_q  <= reg2dp_partial_width_out_last;
                height_q  <= reg2dp_cube_out_height;
                chan_q    <= reg2dp_cube_out_channel;
                pad_l_q   <= reg2dp_pad_left;
                pad_r_q   <= reg2dp_pad_right;
            end
            if (upd) begin
                width_q  <= width_d;
                cur_pl_q <= cur_pl_d;
                cur_pr_q <= cur_pr_d;
                first_q  <= (split_nxt == '0);
                last_q   <= (split_nxt == num_e);
            end
        end
    end

    assign pdp_op_start  = (state_q == SEQ_START);
    assign split_done    = surf_carry;
    assign seq_busy      = busy_q;
    assign dp2reg_done   = done_q;
    assign seq_err       = err_q;
    assign split_first   = first_q;
    assign split_last    = last_q;
    assign cur_width_out = width_q;
    assign cur_pad_left  = cur_pl_q;
    assign cur_pad_right = cur_pr_q;

endmodule

// File: tb/tb_nv_nvdla_pdp_core_seq.sv
// Directed self-checking bench for nv_nvdla_pdp_core_seq.
// Inputs are driven 1ns after the falling edge; outputs are sampled 1ns later,
// well away from the rising (active) edge.
module tb_nv_nvdla_pdp_core_seq;
    import nv_nvdla_pdp_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        op_en;
    logic [7:0]  splitw;
    logic [9:0]  w_first, w_mid, w_last;
    logic [12:0] height, chan;
    logic [2:0]  padl, padr;

    logic        op_start, busy, s_first, s_last, s_done, done, err;
    logic [7:0]  s_idx;
    logic [9:0]  width;
    logic [2:0]  cpl, cpr;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    nv_nvdla_pdp_core_seq_if wdma_if ();

    nv_nvdla_pdp_core_seq #(.SPLIT_W(8), .WID_W(10), .CUBE_W(13)) u_dut (
        .nvdla_core_clk                 (clk),
        .nvdla_core_rstn                (rstn),
        .reg2dp_op_en                   (op_en),
        .reg2dp_splitw_num              (splitw),
        .reg2dp_partial_width_out_first (w_first),
        .reg2dp_partial_width_out_mid   (w_mid),
        .reg2dp_partial_width_out_last  (w_last),
        .reg2dp_cube_out_height         (height),
        .reg2dp_cube_out_channel        (chan),
        .reg2dp_pad_left                (padl),
        .reg2dp_pad_right               (padr),
        .dp2wdma                        (wdma_if),
        .pdp_op_start                   (op_start),
        .seq_busy                       (busy),
        .split_idx                      (s_idx),
        .split_first                    (s_first),
        .split_last                     (s_last),
        .cur_width_out                  (width),
        .cur_pad_left                   (cpl),
        .cur_pad_right                  (cpr),
        .split_done                     (s_done),
        .dp2reg_done                    (done),
        .seq_err                        (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic r);
        nxt();
        wdma_if.dp2wdma_valid = v;
        wdma_if.dp2wdma_ready = r;
        #1;
    endtask

    task automatic set_single();
        splitw = 8'd0; w_first = 10'd3; w_mid = 10'd0; w_last = 10'd0;
        height = 13'd1; chan = 13'd0; padl = 3'd2; padr = 3'd1;
    endtask

    task automatic set_three();
        splitw = 8'd2; w_first = 10'd1; w_mid = 10'd2; w_last = 10'd0;
        height = 13'd0; chan = 13'd1; padl = 3'd5; padr = 3'd3;
    endtask

    // Produce a fresh op_en rising edge and walk through START into RUN.
    task automatic start_op();
        drv(1'b0, 1'b0);
        op_en = 1'b0;
        drv(1'b0, 1'b0);
        op_en = 1'b1;
        drv(1'b0, 1'b0);
        chk("start_pulse", op_start, 1);
        chk("start_busy", busy, 1);
        drv(1'b0, 1'b0);
        chk("run_no_start", op_start, 0);
    endtask

    // Single-split op: 4 wide x 2 lines x 1 surface = 8 beats.
    task automatic run_single(input bit bp);
        int acc;
        int cyc;
        logic r;
        set_single();
        start_op();
        chk("s_width", width, 3);
        chk("s_padl", cpl, 2);
        chk("s_padr", cpr, 1);
        chk("s_first", s_first, 1);
        chk("s_last", s_last, 1);
        chk("s_err_clr", err, 0);
        acc = 0;
        cyc = 0;
        while (acc < 8 && cyc < 40) begin
            r = bp ? ((cyc % 2) == 0) : 1'b1;
            drv(1'b1, r);
            chk("s_split_done", s_done, (r && acc == 7));
            chk("s_no_early_done", done, 0);
            if (r) acc++;
            cyc++;
        end
        drv(1'b0, 1'b0);
        chk("s_done_pulse", done, 1);
        chk("s_done_busy", busy, 1);
        drv(1'b0, 1'b0);
        chk("s_done_end", done, 0);
        chk("s_idle_busy", busy, 0);
    endtask

    initial begin
        rstn = 1'b0;
        op_en = 1'b0;
        wdma_if.dp2wdma_valid = 1'b0;
        wdma_if.dp2wdma_ready = 1'b0;
        set_single();
        nxt();
        nxt();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_first", s_first, 1);
        chk("rst_last", s_last, 0);
        chk("rst_width", width, 0);
        chk("rst_padl", cpl, 0);
        chk("rst_padr", cpr, 0);
        chk("rst_idx", s_idx, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_start", op_start, 0);
        rstn = 1'b1;

        // Single split, full throughput
        run_single(1'b0);
        // op_en stays high: no restart
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 1'b0);
            chk("hold_no_start", op_start, 0);
            chk("hold_idle", busy, 0);
        end

        // Three splits: 4 + 6 + 2 beats
        set_three();
        start_op();
        for (int i = 1; i <= 12; i++) begin
            drv(1'b1, 1'b1);
            chk("t_width", width, (i <= 4) ? 1 : (i <= 10) ? 2 : 0);
            chk("t_idx", s_idx, (i <= 4) ? 0 : (i <= 10) ? 1 : 2);
            chk("t_padl", cpl, (i <= 4) ? 5 : 0);
            chk("t_padr", cpr, (i > 10) ? 3 : 0);
            chk("t_first", s_first, (i <= 4));
            chk("t_last", s_last, (i > 10));
            chk("t_split_done", s_done, (i == 4 || i == 10 || i == 12));
        end
        drv(1'b0, 1'b0);
        chk("t_done_pulse", done, 1);
        drv(1'b0, 1'b0);
        chk("t_done_end", done, 0);

        // Backpressure: ready toggles, still exactly 8 accepted beats
        run_single(1'b1);

        // Abort after 5 beats
        set_single();
        start_op();
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 1'b1);
            chk("a_split_done", s_done, 0);
        end
        drv(1'b0, 1'b0);
        op_en = 1'b0;
        drv(1'b0, 1'b0);
        chk("a_busy_drop", busy, 0);
        chk("a_no_done", done, 0);
        chk("a_idx_clr", s_idx, 0);
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 1'b0);
            chk("a_quiet", done, 0);
        end
        run_single(1'b0);

        // Beats while IDLE
        drv(1'b1, 1'b1);
        drv(1'b1, 1'b1);
        drv(1'b0, 1'b0);
        chk("e_err_set", err, 1);
        chk("e_idle", busy, 0);
        chk("e_idx", s_idx, 0);
        drv(1'b0, 1'b0);
        chk("e_err_sticky", err, 1);
        run_single(1'b0);

        // Reset in the middle of RUN
        set_single();
        start_op();
        for (int i = 0; i < 3; i++) drv(1'b1, 1'b1);
        nxt();
        rstn = 1'b0;
        op_en = 1'b0;
        #1;
        chk("r_busy", busy, 0);
        chk("r_first", s_first, 1);
        chk("r_last", s_last, 0);
        chk("r_width", width, 0);
        chk("r_padl", cpl, 0);
        chk("r_padr", cpr, 0);
        chk("r_idx", s_idx, 0);
        chk("r_done", done, 0);
        chk("r_split_done", s_done, 0);
        nxt();
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drv(1'b1, 1'b1);
            chk("r_no_done", done, 0);
            chk("r_no_busy", busy, 0);
        end
        drv(1'b0, 1'b0);
        run_single(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
